// File: rtl/multicycle_control.sv
// Moore control FSM for a multicycle MIPS-style datapath with a bounded memory handshake.
// Optional JAL support is compiled in when MULTICYCLE_JAL_EN is defined.
module multicycle_control #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       branch_ne,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       we_memory,
    output logic       ir_write,
    output logic       ALU_src_A,
    output logic       register_write,
    output logic       fault,
    output logic [1:0] ALU_src_B,
    output logic [1:0] ALU_OP,
    output logic [1:0] pc_source,
    output logic [1:0] destination_register,
    output logic [1:0] memory_to_register,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_R_EXEC   = 4'd6,
        S_R_WB     = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9,
        S_I_EXEC   = 4'd10,
        S_I_WB     = 4'd11,
`ifdef MULTICYCLE_JAL_EN
        S_JAL      = 4'd12,
`endif
        S_FAULT    = 4'd15
    } state_t;

    typedef struct packed {
        logic       pc_write_fixed;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       we_memory;
        logic       alu_src_a;
        logic       register_write;
        logic       fault;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic [1:0] destination_register;
        logic [1:0] memory_to_register;
    } ctrl_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [7:0] TIMEOUT  = 8'(MEM_TIMEOUT);

    state_t     cur_state;
    state_t     next_state;
    ctrl_t      ctrl_q;
    logic [7:0] wait_count;
    logic       mem_state;
    logic       timed_out;
    logic       fetch_strobe;

    // Control word for a state; the mem_ready strobes are added outside.
    function automatic ctrl_t decode_ctrl(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.mem_read  = 1'b1;
                c.alu_src_b = 2'b01;
            end
            S_DECODE:   c.alu_src_b = 2'b11;
            S_MEM_ADDR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
            end
            S_MEM_RD: begin
                c.mem_read = 1'b1;
                c.i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                c.register_write     = 1'b1;
                c.memory_to_register = 2'b01;
            end
            S_MEM_WR: begin
                c.we_memory = 1'b1;
                c.i_or_d    = 1'b1;
            end
            S_R_EXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = 2'b11;
            end
            S_R_WB: begin
                c.register_write       = 1'b1;
                c.destination_register = 2'b01;
            end
            S_BRANCH: begin
                c.alu_src_a     = 1'b1;
                c.alu_op        = 2'b01;
                c.pc_write_cond = 1'b1;
                c.pc_source     = 2'b01;
            end
            S_JUMP: begin
                c.pc_write_fixed = 1'b1;
                c.pc_source      = 2'b10;
            end
            S_I_EXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
                c.alu_op    = 2'b10;
            end
            S_I_WB:     c.register_write = 1'b1;
`ifdef MULTICYCLE_JAL_EN
            S_JAL: begin
                c.pc_write_fixed       = 1'b1;
                c.pc_source            = 2'b10;
                c.register_write       = 1'b1;
                c.destination_register = 2'b10;
                c.memory_to_register   = 2'b10;
            end
`endif
            S_FAULT:    c.fault = 1'b1;
            default:    c.fault = 1'b1;
        endcase
        return c;
    endfunction

    assign mem_state = (cur_state == S_FETCH) || (cur_state == S_MEM_RD) ||
                       (cur_state == S_MEM_WR);
    assign timed_out = (wait_count == TIMEOUT);

    always_comb begin
        next_state = cur_state;
        case (cur_state)
            S_FETCH: begin
                if (mem_ready)      next_state = S_DECODE;
                else if (timed_out) next_state = S_FAULT;
            end
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:                           next_state = S_R_EXEC;
                    OP_LW, OP_SW:                       next_state = S_MEM_ADDR;
                    OP_BEQ, OP_BNE:                     next_state = S_BRANCH;
                    OP_J:                               next_state = S_JUMP;
                    OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI:  next_state = S_I_EXEC;
`ifdef MULTICYCLE_JAL_EN
                    OP_JAL:                             next_state = S_JAL;
`else
                    OP_JAL:                             next_state = S_FAULT;
`endif
                    default:                            next_state = S_FAULT;
                endcase
            end
            S_MEM_ADDR: next_state = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD: begin
                if (mem_ready)      next_state = S_MEM_WB;
                else if (timed_out) next_state = S_FAULT;
            end
            S_MEM_WR: begin
                if (mem_ready)      next_state = S_FETCH;
                else if (timed_out) next_state = S_FAULT;
            end
            S_R_EXEC:   next_state = S_R_WB;
            S_I_EXEC:   next_state = S_I_WB;
            S_MEM_WB, S_R_WB, S_I_WB, S_BRANCH, S_JUMP: next_state = S_FETCH;
`ifdef MULTICYCLE_JAL_EN
            S_JAL:      next_state = S_FETCH;
`endif
            S_FAULT:    next_state = S_FAULT;
            default:    next_state = S_FAULT;
        endcase
    end

    // The control word is registered from next_state so it lines up with cur_state.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_state  <= S_FETCH;
            ctrl_q     <= decode_ctrl(S_FETCH);
            wait_count <= 8'd0;
        end else begin
            cur_state <= next_state;
            ctrl_q    <= decode_ctrl(next_state);
            if (next_state != cur_state)
                wait_count <= 8'd0;
            else if (mem_state && !mem_ready)
                wait_count <= wait_count + 8'd1;
        end
    end

    assign fetch_strobe         = !rst && (cur_state == S_FETCH) && mem_ready;
    assign pc_write             = !rst && (ctrl_q.pc_write_fixed || fetch_strobe);
    assign ir_write             = fetch_strobe;
    assign branch_ne            = (cur_state == S_BRANCH) && (opcode == OP_BNE);
    assign pc_write_cond        = ctrl_q.pc_write_cond;
    assign i_or_d               = ctrl_q.i_or_d;
    assign mem_read             = ctrl_q.mem_read;
    assign we_memory            = ctrl_q.we_memory;
    assign ALU_src_A            = ctrl_q.alu_src_a;
    assign register_write       = ctrl_q.register_write;
    assign fault                = ctrl_q.fault;
    assign ALU_src_B            = ctrl_q.alu_src_b;
    assign ALU_OP               = ctrl_q.alu_op;
    assign pc_source            = ctrl_q.pc_source;
    assign destination_register = ctrl_q.destination_register;
    assign memory_to_register   = ctrl_q.memory_to_register;
    assign state                = cur_state;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: directed vector table, corner sequences,
// and a randomized run against an instruction-path reference model.
module tb_multicycle_control;

    localparam int TO = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] opcode = 6'd0;
    logic       mem_ready = 1'b0;
    logic       pc_write, pc_write_cond, branch_ne, i_or_d, mem_read, we_memory;
    logic       ir_write, ALU_src_A, register_write, fault;
    logic [1:0] ALU_src_B, ALU_OP, pc_source, destination_register, memory_to_register;
    logic [3:0] state;
    logic [19:0] act_vec;

    int checks = 0;
    int errors = 0;

    multicycle_control #(.MEM_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .branch_ne(branch_ne),
        .i_or_d(i_or_d), .mem_read(mem_read), .we_memory(we_memory), .ir_write(ir_write),
        .ALU_src_A(ALU_src_A), .register_write(register_write), .fault(fault),
        .ALU_src_B(ALU_src_B), .ALU_OP(ALU_OP), .pc_source(pc_source),
        .destination_register(destination_register),
        .memory_to_register(memory_to_register), .state(state)
    );

    always #5 clk = ~clk;

    assign act_vec = {pc_write, pc_write_cond, branch_ne, i_or_d, mem_read, we_memory,
                      ir_write, ALU_src_A, register_write, fault, ALU_src_B, ALU_OP,
                      pc_source, destination_register, memory_to_register};

    // Expected control outputs for a state number, written straight from the state table.
    function automatic logic [19:0] exp_outputs(input int st, input logic [5:0] op,
                                                input logic mr, input logic rs);
        logic pcw, pwc, bne, iod, mrd, wem, irw, sa, rw, flt;
        logic [1:0] sb, aop, psrc, dst, m2r;
        {pcw, pwc, bne, iod, mrd, wem, irw, sa, rw, flt} = 10'd0;
        {sb, aop, psrc, dst, m2r} = 10'd0;
        case (st)
            0:  begin mrd = 1; sb = 2'b01; irw = mr & ~rs; pcw = mr & ~rs; end
            1:  sb = 2'b11;
            2:  begin sa = 1; sb = 2'b10; end
            3:  begin mrd = 1; iod = 1; end
            4:  begin rw = 1; m2r = 2'b01; end
            5:  begin wem = 1; iod = 1; end
            6:  begin sa = 1; aop = 2'b11; end
            7:  begin rw = 1; dst = 2'b01; end
            8:  begin sa = 1; aop = 2'b01; pwc = 1; psrc = 2'b01; bne = (op == 6'b000101); end
            9:  begin pcw = ~rs; psrc = 2'b10; end
            10: begin sa = 1; sb = 2'b10; aop = 2'b10; end
            11: rw = 1;
            12: begin pcw = ~rs; psrc = 2'b10; rw = 1; dst = 2'b10; m2r = 2'b10; end
            default: flt = 1;
        endcase
        return {pcw, pwc, bne, iod, mrd, wem, irw, sa, rw, flt, sb, aop, psrc, dst, m2r};
    endfunction

    task automatic applyStimulus(input logic [5:0] op, input logic mr);
        @(negedge clk);
        rst = 1'b0;
        opcode = op;
        mem_ready = mr;
        #1;
    endtask

    task automatic checkOutput(input string name, input int exp_st);
        logic [19:0] ev;
        ev = exp_outputs(exp_st, opcode, mem_ready, rst);
        checks++;
        if (state !== 4'(exp_st)) begin
            errors++;
            $display("[TB] FAIL %s state: got %0d expected %0d", name, state, exp_st);
        end
        checks++;
        if (act_vec !== ev) begin
            errors++;
            $display("[TB] FAIL %s outputs (state %0d): got %b expected %b", name, exp_st, act_vec, ev);
        end
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b1;
        mem_ready = 1'b1;
        opcode = 6'd0;
        @(negedge clk);
        #1;
        checkOutput("reset", 0);
    endtask

    typedef struct {
        logic [5:0] op;
        logic       mr;
        int         exp_state;
    } vec_t;

    vec_t vecs[19];

    // Reference model: an instruction is a list of states, memory states wait for mem_ready.
    int         path[$];
    int         idx;
    int         waited;
    bit         in_fault;
    int         fault_cycles;
    logic [5:0] cur_op;
    logic [5:0] op_list[11];

    function automatic bit is_mem(input int st);
        return (st == 0) || (st == 3) || (st == 5);
    endfunction

    task automatic buildPath(input logic [5:0] op);
        path = {0, 1};
        case (op)
            6'b000000:                                   path = {path, 6, 7};
            6'b100011:                                   path = {path, 2, 3, 4};
            6'b101011:                                   path = {path, 2, 5};
            6'b000100, 6'b000101:                        path.push_back(8);
            6'b000010:                                   path.push_back(9);
            6'b001000, 6'b001010, 6'b001100, 6'b001101:  path = {path, 10, 11};
`ifdef MULTICYCLE_JAL_EN
            6'b000011:                                   path.push_back(12);
`endif
            default:                                     path.push_back(15);
        endcase
    endtask

    task automatic newInstr();
        if ($urandom_range(0, 99) < 10) cur_op = 6'($urandom_range(0, 63));
        else cur_op = op_list[$urandom_range(0, 10)];
        buildPath(cur_op);
        idx = 0;
        waited = 0;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int exp_st;
        logic mr;

        vecs[0]  = '{6'b000000, 1'b1, 0};
        vecs[1]  = '{6'b000000, 1'b1, 1};
        vecs[2]  = '{6'b000000, 1'b1, 6};
        vecs[3]  = '{6'b000000, 1'b1, 7};
        vecs[4]  = '{6'b100011, 1'b1, 0};
        vecs[5]  = '{6'b100011, 1'b1, 1};
        vecs[6]  = '{6'b100011, 1'b1, 2};
        vecs[7]  = '{6'b100011, 1'b0, 3};
        vecs[8]  = '{6'b100011, 1'b0, 3};
        vecs[9]  = '{6'b100011, 1'b0, 3};
        vecs[10] = '{6'b100011, 1'b1, 3};
        vecs[11] = '{6'b100011, 1'b1, 4};
        vecs[12] = '{6'b000101, 1'b1, 0};
        vecs[13] = '{6'b000101, 1'b1, 1};
        vecs[14] = '{6'b000101, 1'b1, 8};
        vecs[15] = '{6'b000010, 1'b1, 0};
        vecs[16] = '{6'b000010, 1'b1, 1};
        vecs[17] = '{6'b000010, 1'b1, 9};
        vecs[18] = '{6'b001101, 1'b0, 0};

        op_list = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101, 6'b000010,
                    6'b001000, 6'b001010, 6'b001100, 6'b001101, 6'b000011};

        $display("[TB] directed vector table");
        doReset();
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].op, vecs[i].mr);
            checkOutput($sformatf("vec%0d", i), vecs[i].exp_state);
        end

        $display("[TB] fetch timeout");
        doReset();
        for (int i = 0; i < TO + 1; i++) begin
            applyStimulus(6'b000000, 1'b0);
            checkOutput("timeout_wait", 0);
        end
        for (int i = 0; i < 3; i++) begin
            applyStimulus(6'b000000, 1'b1);
            checkOutput("timeout_sticky", 15);
        end

        $display("[TB] ready on last allowed cycle");
        doReset();
        for (int i = 0; i < TO; i++) begin
            applyStimulus(6'b000000, 1'b0);
            checkOutput("ready_wait", 0);
        end
        applyStimulus(6'b000000, 1'b1);
        checkOutput("ready_wins", 0);
        applyStimulus(6'b000000, 1'b1);
        checkOutput("ready_decode", 1);

        $display("[TB] reset during store");
        doReset();
        applyStimulus(6'b101011, 1'b1); checkOutput("sw_fetch", 0);
        applyStimulus(6'b101011, 1'b1); checkOutput("sw_decode", 1);
        applyStimulus(6'b101011, 1'b1); checkOutput("sw_addr", 2);
        applyStimulus(6'b101011, 1'b0); checkOutput("sw_wait", 5);
        applyStimulus(6'b101011, 1'b0); checkOutput("sw_wait", 5);
        @(negedge clk);
        rst = 1'b1;
        mem_ready = 1'b0;
        #1;
        checkOutput("sw_rst_pending", 5);
        @(negedge clk);
        #1;
        checkOutput("sw_rst_applied", 0);
        for (int i = 0; i < TO + 1; i++) begin
            applyStimulus(6'b101011, 1'b0);
            checkOutput("sw_cnt_cleared", 0);
        end
        applyStimulus(6'b101011, 1'b0);
        checkOutput("sw_cnt_fault", 15);

        $display("[TB] jal and illegal opcodes");
        doReset();
        applyStimulus(6'b000011, 1'b1); checkOutput("jal_fetch", 0);
        applyStimulus(6'b000011, 1'b1); checkOutput("jal_decode", 1);
        applyStimulus(6'b000011, 1'b1);
`ifdef MULTICYCLE_JAL_EN
        checkOutput("jal_state", 12);
        applyStimulus(6'b000011, 1'b1); checkOutput("jal_return", 0);
`else
        checkOutput("jal_absent", 15);
`endif
        doReset();
        applyStimulus(6'b111111, 1'b1); checkOutput("ill_fetch", 0);
        applyStimulus(6'b111111, 1'b1); checkOutput("ill_decode", 1);
        applyStimulus(6'b111111, 1'b1); checkOutput("ill_fault", 15);

        $display("[TB] randomized run");
        doReset();
        newInstr();
        in_fault = 0;
        fault_cycles = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            exp_st = in_fault ? 15 : path[idx];
            mr = ($urandom_range(0, 99) < 65);
            applyStimulus(cur_op, mr);
            checkOutput("random", exp_st);
            if (in_fault || exp_st == 15) begin
                in_fault = 1;
                fault_cycles++;
                if (fault_cycles >= 3) begin
                    doReset();
                    in_fault = 0;
                    fault_cycles = 0;
                    newInstr();
                end
            end else if (is_mem(exp_st)) begin
                if (mr) begin
                    idx++;
                    waited = 0;
                end else if (waited == TO) begin
                    in_fault = 1;
                end else begin
                    waited++;
                end
            end else begin
                idx++;
            end
            if (!in_fault && idx >= path.size()) newInstr();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter: MEM_TIMEOUT, default 15, max cycles to wait for mem_ready in any memory state before faulting (1..255).
REQ-002 Port: clk  in  1  rising-edge clock.
REQ-003 Port: rst  in  1  synchronous, active-high reset.
REQ-004 Port: opcode  in  6  instruction[31:26], sampled from the instruction register.
REQ-005 Port: mem_ready  in  1  memory handshake; access completes in the cycle it is high.
REQ-006 Ports, all out, 1 bit: pc_write, pc_write_cond, branch_ne, i_or_d, mem_read, we_memory, ir_write, ALU_src_A, register_write, fault.
REQ-007 Ports, all out, 2 bits: ALU_src_B (00 reg, 01 const 4, 10 sext imm, 11 sext imm<<2), ALU_OP (00 add, 01 sub, 10 imm-decode, 11 funct), pc_source (00 ALU, 01 ALUOut, 10 jump target), destination_register (00 rt, 01 rd, 10 $31), memory_to_register (00 ALUOut, 01 MDR, 10 PC).
REQ-008 Port: state  out  4  current state encoding, for debug.

Function
REQ-009 Block SHALL be a Moore FSM; all outputs except the mem_ready-qualified strobes (pc_write, ir_write) SHALL be decoded from state only.
REQ-010 States/encodings: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_RD 3, MEM_WB 4, MEM_WR 5, R_EXEC 6, R_WB 7, BRANCH 8, JUMP 9, I_EXEC 10, I_WB 11, JAL 12, FAULT 15.
REQ-011 FETCH: mem_read=1, i_or_d=0, ALU_src_A=0, ALU_src_B=01, ALU_OP=00, pc_source=00; ir_write=pc_write=mem_ready; advance to DECODE only on mem_ready.
REQ-012 DECODE: ALU_src_A=0, ALU_src_B=11, ALU_OP=00 (branch target precompute); next state from opcode, one cycle.
REQ-013 Decode: 000000->R_EXEC; 100011/101011->MEM_ADDR; 000100/000101->BRANCH; 000010->JUMP; 001000/001010/001100/001101->I_EXEC; 000011->JAL (REQ-027); any other->FAULT.
REQ-014 MEM_ADDR: ALU_src_A=1, ALU_src_B=10, ALU_OP=00; ->MEM_RD if LW, ->MEM_WR if SW.
REQ-015 MEM_RD: mem_read=1, i_or_d=1; ->MEM_WB on mem_ready, else hold. MEM_WB: register_write=1, destination_register=00, memory_to_register=01; ->FETCH.
REQ-016 MEM_WR: we_memory=1, i_or_d=1; ->FETCH on mem_ready, else hold.
REQ-017 R_EXEC: ALU_src_A=1, ALU_src_B=00, ALU_OP=11; ->R_WB. R_WB: register_write=1, destination_register=01, memory_to_register=00; ->FETCH.
REQ-018 I_EXEC: ALU_src_A=1, ALU_src_B=10, ALU_OP=10; ->I_WB. I_WB: register_write=1, destination_register=00, memory_to_register=00; ->FETCH.
REQ-019 BRANCH: ALU_src_A=1, ALU_src_B=00, ALU_OP=01, pc_write_cond=1, pc_source=01, branch_ne=(opcode==000101); ->FETCH.
REQ-020 JUMP: pc_write=1, pc_source=10; ->FETCH.
REQ-021 Memory wait counter (8 bit) SHALL clear on entry to FETCH/MEM_RD/MEM_WR, increment each cycle waiting with mem_ready=0; reaching MEM_TIMEOUT with mem_ready still 0 ->FAULT.
REQ-022 mem_ready high in the same cycle counter reaches MEM_TIMEOUT SHALL complete the access (ready wins).
REQ-023 FAULT: fault=1, all write/strobe outputs 0; sticky until rst.
REQ-024 Any output not listed for a state SHALL be 0; opcode ignored outside DECODE, MEM_ADDR, BRANCH.

Reset
REQ-025 rst=1 at a clock edge SHALL force FETCH, clear wait counter and fault, overriding any in-progress memory access; rst has priority over all transitions.
REQ-026 After reset, first FETCH cycle SHALL present FETCH outputs; pc_write/ir_write stay 0 while rst is high.

Configuration
REQ-027 Macro MULTICYCLE_JAL_EN: when defined, opcode 000011 ->JAL state: pc_write=1, pc_source=10, register_write=1, destination_register=10, memory_to_register=10; ->FETCH. When undefined, 000011 decodes to FAULT and JAL state is absent.

Verification
REQ-028 rst, then opcode=000000, mem_ready=1 -> states 0,1,6,7,0; register_write=1 only in state 7 with destination_register=01.
REQ-029 LW opcode=100011, mem_ready low 3 cycles in MEM_RD -> state 3 held 4 cycles, then 4 with memory_to_register=01, then 0.
REQ-030 MEM_TIMEOUT=4, mem_ready=0 in FETCH -> fault=1 and state=15 after 5 FETCH cycles; stays until rst.
REQ-031 BNE opcode=000101 -> BRANCH with pc_write_cond=1, branch_ne=1, ALU_OP=01, pc_source=01.
REQ-032 opcode=000011: with MULTICYCLE_JAL_EN -> state 12, destination_register=10; without -> state 15, fault=1.
REQ-033 rst asserted mid-MEM_WR -> next cycle state=0, we_memory=0, counter cleared.
